// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-requester round-robin APB master with PREADY timeout
module apb_master_arbiter #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic [1:0]          req_i,
    input  logic [1:0]          we_i,
    input  logic [2*ADDR_W-1:0] addr_i,
    input  logic [2*DATA_W-1:0] wdata_i,
    output logic [1:0]          done_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                err_o,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam int             CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    state_t              state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic                gnt, gnt_n;
    logic                last, last_n;
    logic                psel_n, penable_n, pwrite_n, err_n;
    logic [ADDR_W-1:0]   paddr_n;
    logic [DATA_W-1:0]   pwdata_n, rdata_n;
    logic [1:0]          done_n, req_eff;
    logic                win;

    // A requester whose done pulse is showing cannot win again this cycle.
    assign req_eff = req_i & ~done_o;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        gnt_n     = gnt;
        last_n    = last;
        psel_n    = psel;
        penable_n = penable;
        pwrite_n  = pwrite;
        paddr_n   = paddr;
        pwdata_n  = pwdata;
        done_n    = 2'b00;
        err_n     = 1'b0;
        rdata_n   = '0;
        win       = 1'b0;
        case (state)
            IDLE: begin
                psel_n    = 1'b0;
                penable_n = 1'b0;
                if (req_eff != 2'b00) begin
                    win       = (req_eff == 2'b11) ? ~last : req_eff[1];
                    gnt_n     = win;
                    last_n    = win;
                    pwrite_n  = we_i[win];
                    paddr_n   = win ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
                    pwdata_n  = win ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
                    psel_n    = 1'b1;
                    state_n   = SETUP;
                end
            end
            SETUP: begin
                penable_n = 1'b1;
                cnt_n     = '0;
                state_n   = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    done_n    = gnt ? 2'b10 : 2'b01;
                    err_n     = pslverr;
                    rdata_n   = pwrite ? '0 : prdata;
                    state_n   = IDLE;
                end else if (cnt == CNT_LAST) begin
                    psel_n    = 1'b0;
                    penable_n = 1'b0;
                    done_n    = gnt ? 2'b10 : 2'b01;
                    err_n     = 1'b1;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state   <= IDLE;
            cnt     <= '0;
            gnt     <= 1'b0;
            last    <= 1'b1;
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            done_o  <= 2'b00;
            err_o   <= 1'b0;
            rdata_o <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            gnt     <= gnt_n;
            last    <= last_n;
            psel    <= psel_n;
            penable <= penable_n;
            pwrite  <= pwrite_n;
            paddr   <= paddr_n;
            pwdata  <= pwdata_n;
            done_o  <= done_n;
            err_o   <= err_n;
            rdata_o <= rdata_n;
        end
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - randomized self-checking bench with arbitration reference model
module tb_apb_master_arbiter;
    localparam int TIMEOUT = 16;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [1:0]  req, we, done_o;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  rdata_o, pwdata, prdata;
    logic        err_o, psel, penable, pwrite, pready, pslverr;
    logic [3:0]  paddr;

    int passed = 0;
    int total  = 0;

    // Reference model: who was granted last and who is showing a done pulse.
    logic        m_last;
    logic [1:0]  m_masked;

    apb_master_arbiter #(.ADDR_W(4), .DATA_W(8), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .presetn(presetn), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One transfer from IDLE; waits>=TIMEOUT means the slave never answers.
    task automatic xfer(input int waits, input logic serr, input logic [7:0] rd);
        logic [1:0] eff;
        int         w, n_acc;
        logic       ew, timed;
        logic [3:0] ea;
        logic [7:0] ed;
        eff = req & ~m_masked;
        if (eff == 2'b00) begin
            @(negedge pclk);
            chk("masked_idle", {psel, penable}, 2'b00);
            m_masked = 2'b00;
            eff = req;
        end
        w  = (eff == 2'b11) ? int'(!m_last) : (eff[1] ? 1 : 0);
        ew = we[w];
        ea = addr[w*4 +: 4];
        ed = wdata[w*8 +: 8];
        @(negedge pclk);
        chk("setup_phase", {psel, penable}, 2'b10);
        chk("done_cleared", done_o, 2'b00);
        chk("setup_paddr", paddr, ea);
        chk("setup_pwrite", pwrite, ew);
        chk("setup_pwdata", pwdata, ed);
        we    = 2'($urandom);
        addr  = 8'($urandom);
        wdata = 16'($urandom);
        @(negedge pclk);
        chk("access_phase", {psel, penable}, 2'b11);
        timed = (waits >= TIMEOUT);
        n_acc = timed ? TIMEOUT : waits + 1;
        for (int i = 0; i < n_acc; i++) begin
            pready  = (i == waits);
            prdata  = rd;
            pslverr = serr;
            @(negedge pclk);
            if (i == n_acc - 1) begin
                chk("done_pulse", done_o, (w == 1) ? 2'b10 : 2'b01);
                chk("done_err", err_o, timed ? 1'b1 : serr);
                chk("done_rdata", rdata_o, (timed || ew) ? 8'h00 : rd);
                chk("bus_released", {psel, penable}, 2'b00);
            end else begin
                chk("wait_state", {psel, penable, done_o}, 4'b1100);
                chk("wait_paddr", paddr, ea);
            end
        end
        pready   = 1'b0;
        pslverr  = 1'b0;
        m_last   = (w == 1);
        m_masked = (w == 1) ? 2'b10 : 2'b01;
    endtask

    initial begin
        presetn = 1'b0;
        req = 2'b11; we = 2'b00; addr = 8'h00; wdata = 16'h0000;
        prdata = 8'h00; pready = 1'b0; pslverr = 1'b0;
        m_last = 1'b1; m_masked = 2'b00;

        repeat (3) begin
            @(negedge pclk);
            chk("reset_bus", {psel, penable, pwrite, paddr, pwdata}, 0);
            chk("reset_resp", {done_o, err_o, rdata_o}, 0);
        end
        req = 2'b00;
        presetn = 1'b1;
        @(negedge pclk);

        req = 2'b01; we = 2'b01; addr = 8'h01; wdata = 16'h00AA;
        xfer(0, 1'b0, 8'h00);

        req = 2'b10; we = 2'b00; addr = 8'h10;
        xfer(3, 1'b0, 8'hAA);

        req = 2'b11; addr = 8'h5A; wdata = 16'h3C96;
        repeat (4) begin
            we = 2'b11; addr = 8'h5A;
            xfer(0, 1'b0, 8'h00);
        end

        req = 2'b01; we = 2'b00; addr = 8'h07;
        xfer(TIMEOUT, 1'b0, 8'h55);
        xfer(0, 1'b1, 8'h33);

        for (int k = 0; k < 30; k++) begin
            req   = 2'($urandom_range(1, 3));
            we    = 2'($urandom);
            addr  = 8'($urandom);
            wdata = 16'($urandom);
            xfer(($urandom_range(0, 7) == 0) ? TIMEOUT : int'($urandom_range(0, 3)),
                 1'($urandom), 8'($urandom));
        end

        req = 2'b00;
        @(negedge pclk);
        req = 2'b01; we = 2'b01; addr = 8'h03; wdata = 16'h0011;
        @(negedge pclk);
        @(negedge pclk);
        @(negedge pclk);
        chk("pre_reset_access", {psel, penable}, 2'b11);
        presetn = 1'b0;
        @(negedge pclk);
        chk("midreset_bus", {psel, penable, done_o}, 4'b0000);
        presetn = 1'b1;
        req = 2'b00;
        @(negedge pclk);
        chk("dropped_no_done", done_o, 2'b00);
        m_last = 1'b1; m_masked = 2'b00;
        req = 2'b11; we = 2'b00; addr = 8'h42;
        xfer(1, 1'b0, 8'hC3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
